// File: rtl/axilite2avmm_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge with one-deep AW/W/AR capture and round-robin arbitration.
// Optional macro AXILITE2AVMM_TIMEOUT_EN adds an AVMM response timeout that returns SLVERR.
module axilite2avmm_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    axi_lite_awvalid_i,
    output logic                    axi_lite_awready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_lite_awaddr_i,
    input  logic [2:0]              axi_lite_awprot_i,
    input  logic                    axi_lite_wvalid_i,
    output logic                    axi_lite_wready_o,
    input  logic [DATA_WIDTH-1:0]   axi_lite_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] axi_lite_wstrb_i,
    output logic                    axi_lite_bvalid_o,
    input  logic                    axi_lite_bready_i,
    output logic [1:0]              axi_lite_bresp_o,
    input  logic                    axi_lite_arvalid_i,
    output logic                    axi_lite_arready_o,
    input  logic [ADDR_WIDTH-1:0]   axi_lite_araddr_i,
    input  logic [2:0]              axi_lite_arprot_i,
    output logic                    axi_lite_rvalid_o,
    input  logic                    axi_lite_rready_i,
    output logic [DATA_WIDTH-1:0]   axi_lite_rdata_o,
    output logic [1:0]              axi_lite_rresp_o,
    output logic [ADDR_WIDTH-1:0]   avmm_address_o,
    output logic [DATA_WIDTH-1:0]   avmm_writedata_o,
    output logic [DATA_WIDTH/8-1:0] avmm_byteenable_o,
    output logic                    avmm_write_o,
    output logic                    avmm_read_o,
    input  logic                    avmm_waitrequest_i,
    input  logic [DATA_WIDTH-1:0]   avmm_readdata_i,
    input  logic                    avmm_readdatavalid_i,
    output logic [2:0]              dbg_state_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_CMD  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_CMD  = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_RD_RESP = 3'd5;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]              r_state;
    logic                    r_aw_full, r_w_full, r_ar_full, r_prefer_rd;
    logic [ADDR_WIDTH-1:0]   r_aw_addr, r_ar_addr, r_avm_addr;
    logic [DATA_WIDTH-1:0]   r_w_data, r_avm_wdata, r_rdata;
    logic [DATA_WIDTH/8-1:0] r_w_strb, r_avm_be;
    logic [1:0]              r_bresp, r_rresp;

    logic [2:0] w_next_state;
    logic       w_wr_pend, w_rd_pend, w_grant_wr, w_grant_rd;
    logic       w_wr_accept, w_rd_accept, w_wr_tmo, w_rd_tmo;
    logic       w_unused;

    assign w_wr_pend   = r_aw_full & r_w_full;
    assign w_rd_pend   = r_ar_full;
    // Both pending: serve the side opposite to the one granted last.
    assign w_grant_wr  = (r_state == S_IDLE) && w_wr_pend && (!w_rd_pend || !r_prefer_rd);
    assign w_grant_rd  = (r_state == S_IDLE) && w_rd_pend && (!w_wr_pend || r_prefer_rd);
    assign w_wr_accept = (r_state == S_WR_CMD) && !avmm_waitrequest_i;
    assign w_rd_accept = (r_state == S_RD_CMD) && !avmm_waitrequest_i;

`ifdef AXILITE2AVMM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             w_timed_state, w_tmo_hit;

    assign w_timed_state = (r_state == S_WR_CMD) || (r_state == S_RD_CMD) || (r_state == S_RD_WAIT);
    assign w_tmo_hit     = w_timed_state && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_wr_tmo      = w_tmo_hit && (r_state == S_WR_CMD) && avmm_waitrequest_i;
    assign w_rd_tmo      = w_tmo_hit && (((r_state == S_RD_CMD) && avmm_waitrequest_i) ||
                                         ((r_state == S_RD_WAIT) && !avmm_readdatavalid_i));

    // Restarts on every state entry so each phase gets the full budget.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            r_tmo_cnt <= '0;
        else if (w_next_state != r_state)
            r_tmo_cnt <= '0;
        else if (w_timed_state && !w_tmo_hit)
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
`else
    localparam int tmo_cycles_unused = TIMEOUT_CYCLES;
    assign w_wr_tmo = 1'b0;
    assign w_rd_tmo = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_grant_wr) w_next_state = S_WR_CMD;
                       else if (w_grant_rd) w_next_state = S_RD_CMD;
            S_WR_CMD:  if (w_wr_accept || w_wr_tmo) w_next_state = S_WR_RESP;
            S_WR_RESP: if (axi_lite_bready_i) w_next_state = S_IDLE;
            S_RD_CMD:  if (w_rd_accept) w_next_state = S_RD_WAIT;
                       else if (w_rd_tmo) w_next_state = S_RD_RESP;
            S_RD_WAIT: if (avmm_readdatavalid_i || w_rd_tmo) w_next_state = S_RD_RESP;
            S_RD_RESP: if (axi_lite_rready_i) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_aw_full   <= 1'b0;
            r_w_full    <= 1'b0;
            r_ar_full   <= 1'b0;
            r_prefer_rd <= 1'b0;
            r_aw_addr   <= '0;
            r_ar_addr   <= '0;
            r_avm_addr  <= '0;
            r_w_data    <= '0;
            r_avm_wdata <= '0;
            r_rdata     <= '0;
            r_w_strb    <= '0;
            r_avm_be    <= '0;
            r_bresp     <= RESP_OKAY;
            r_rresp     <= RESP_OKAY;
        end else begin
            r_state <= w_next_state;

            if (axi_lite_awvalid_i && !r_aw_full) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= axi_lite_awaddr_i;
            end else if (w_wr_accept || w_wr_tmo) begin
                r_aw_full <= 1'b0;
            end

            if (axi_lite_wvalid_i && !r_w_full) begin
                r_w_full <= 1'b1;
                r_w_data <= axi_lite_wdata_i;
                r_w_strb <= axi_lite_wstrb_i;
            end else if (w_wr_accept || w_wr_tmo) begin
                r_w_full <= 1'b0;
            end

            // A timeout in RD_WAIT must not drop an AR captured after the command went out.
            if (axi_lite_arvalid_i && !r_ar_full) begin
                r_ar_full <= 1'b1;
                r_ar_addr <= axi_lite_araddr_i;
            end else if (w_rd_accept || (w_rd_tmo && (r_state == S_RD_CMD))) begin
                r_ar_full <= 1'b0;
            end

            if (w_grant_wr) begin
                r_avm_addr  <= {r_aw_addr[ADDR_WIDTH-1:2], 2'b00};
                r_avm_wdata <= r_w_data;
                r_avm_be    <= r_w_strb;
                r_prefer_rd <= 1'b1;
            end else if (w_grant_rd) begin
                r_avm_addr  <= {r_ar_addr[ADDR_WIDTH-1:2], 2'b00};
                r_avm_be    <= '1;
                r_prefer_rd <= 1'b0;
            end

            if (w_wr_accept)
                r_bresp <= RESP_OKAY;
            else if (w_wr_tmo)
                r_bresp <= RESP_SLVERR;

            if ((r_state == S_RD_WAIT) && avmm_readdatavalid_i) begin
                r_rdata <= avmm_readdata_i;
                r_rresp <= RESP_OKAY;
            end else if (w_rd_tmo) begin
                r_rdata <= DATA_WIDTH'(32'hDEAD_BEEF);
                r_rresp <= RESP_SLVERR;
            end
        end
    end

    // AXI handshakes complete on any edge where valid and ready are both high; B/R hold until ready.
    assign axi_lite_awready_o = !r_aw_full;
    assign axi_lite_wready_o  = !r_w_full;
    assign axi_lite_arready_o = !r_ar_full;
    assign axi_lite_bvalid_o  = (r_state == S_WR_RESP);
    assign axi_lite_bresp_o   = r_bresp;
    assign axi_lite_rvalid_o  = (r_state == S_RD_RESP);
    assign axi_lite_rdata_o   = r_rdata;
    assign axi_lite_rresp_o   = r_rresp;
    assign avmm_write_o       = (r_state == S_WR_CMD);
    assign avmm_read_o        = (r_state == S_RD_CMD);
    assign avmm_address_o     = r_avm_addr;
    assign avmm_writedata_o   = r_avm_wdata;
    assign avmm_byteenable_o  = r_avm_be;
    assign dbg_state_o        = r_state;

    assign w_unused = ^{axi_lite_awprot_i, axi_lite_arprot_i, r_aw_addr[1:0], r_ar_addr[1:0]};
endmodule

// File: tb/tb_axilite2avmm_bridge.sv
// Bench for axilite2avmm_bridge: directed scenarios plus randomized single transactions checked
// against a word-memory reference model and an expected AVMM command queue.
module tb_axilite2avmm_bridge;
    logic        aclk, aresetn;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [31:0] avmm_address_o, avmm_writedata_o, avmm_readdata_i;
    logic [3:0]  avmm_byteenable_o;
    logic        avmm_write_o, avmm_read_o, avmm_waitrequest_i, avmm_readdatavalid_i;
    logic [2:0]  dbg_state_unused;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [68:0] exp_q[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] slave_mem[int unsigned];
    int          slave_wait = 0;
    int          slave_lat = 0;
    bit          slave_no_rdv = 0;
    bit          spur_req = 0;
    int          last_cmd_cycles = 0;
    time         acc_time = 0;

    axilite2avmm_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi_lite_awvalid_i(awvalid), .axi_lite_awready_o(awready), .axi_lite_awaddr_i(awaddr),
        .axi_lite_awprot_i(awprot), .axi_lite_wvalid_i(wvalid), .axi_lite_wready_o(wready),
        .axi_lite_wdata_i(wdata), .axi_lite_wstrb_i(wstrb), .axi_lite_bvalid_o(bvalid),
        .axi_lite_bready_i(bready), .axi_lite_bresp_o(bresp), .axi_lite_arvalid_i(arvalid),
        .axi_lite_arready_o(arready), .axi_lite_araddr_i(araddr), .axi_lite_arprot_i(arprot),
        .axi_lite_rvalid_o(rvalid), .axi_lite_rready_i(rready), .axi_lite_rdata_o(rdata),
        .axi_lite_rresp_o(rresp), .avmm_address_o(avmm_address_o), .avmm_writedata_o(avmm_writedata_o),
        .avmm_byteenable_o(avmm_byteenable_o), .avmm_write_o(avmm_write_o), .avmm_read_o(avmm_read_o),
        .avmm_waitrequest_i(avmm_waitrequest_i), .avmm_readdata_i(avmm_readdata_i),
        .avmm_readdatavalid_i(avmm_readdatavalid_i), .dbg_state_o(dbg_state_unused)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned w);
        return 32'hC0DE_0000 ^ (w * 32'h0001_0001);
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic void expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = ref_word(a >> 2);
        for (int b = 0; b < 4; b++)
            if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
        ref_mem[a >> 2] = cur;
        exp_q.push_back({1'b1, a & 32'hFFFF_FFFC, d, s});
    endfunction

    function automatic logic [31:0] expect_read(input logic [31:0] a);
        exp_q.push_back({1'b0, a & 32'hFFFF_FFFC, 32'h0, 4'h0});
        return ref_word(a >> 2);
    endfunction

    // AVMM slave: waitrequest for slave_wait cycles per command, readdatavalid slave_lat cycles later.
    initial begin : avmm_slave
        int           wcnt, rd_cnt, cmd_cycles;
        bit           rd_pend;
        logic [31:0]  rd_data, cur;
        logic [68:0]  obs;
        int unsigned  w;
        wcnt = 0; rd_cnt = 0; cmd_cycles = 0; rd_pend = 0; rd_data = 0;
        avmm_waitrequest_i = 1'b1; avmm_readdatavalid_i = 1'b0; avmm_readdata_i = '0;
        forever begin
            @(negedge aclk);
            check("rd_wr_exclusive", avmm_read_o & avmm_write_o, 1'b0);
            avmm_readdatavalid_i = 1'b0;
            avmm_readdata_i = $urandom;
            if (!aresetn) begin
                rd_pend = 0; wcnt = 0; cmd_cycles = 0; avmm_waitrequest_i = 1'b1;
                continue;
            end
            if (spur_req) begin
                avmm_readdatavalid_i = 1'b1; avmm_readdata_i = 32'h1111_1111; spur_req = 0;
            end
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    avmm_readdatavalid_i = 1'b1; avmm_readdata_i = rd_data; rd_pend = 0;
                end else rd_cnt--;
            end
            if (avmm_read_o || avmm_write_o) begin
                cmd_cycles++;
                if (wcnt < slave_wait) begin
                    avmm_waitrequest_i = 1'b1; wcnt++;
                end else begin
                    avmm_waitrequest_i = 1'b0; wcnt = 0;
                    last_cmd_cycles = cmd_cycles; cmd_cycles = 0; acc_time = $time;
                    obs = avmm_write_o ? {1'b1, avmm_address_o, avmm_writedata_o, avmm_byteenable_o}
                                       : {1'b0, avmm_address_o, 32'h0, 4'h0};
                    check("avmm_cmd_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("avmm_cmd", obs, exp_q.pop_front());
                    w = avmm_address_o >> 2;
                    if (avmm_write_o) begin
                        cur = slave_mem.exists(w) ? slave_mem[w] : init_word(w);
                        for (int b = 0; b < 4; b++)
                            if (avmm_byteenable_o[b]) cur[8*b +: 8] = avmm_writedata_o[8*b +: 8];
                        slave_mem[w] = cur;
                    end else begin
                        rd_data = slave_mem.exists(w) ? slave_mem[w] : init_word(w);
                        rd_pend = !slave_no_rdv; rd_cnt = slave_lat;
                    end
                end
            end else begin
                avmm_waitrequest_i = 1'b1; wcnt = 0; cmd_cycles = 0;
            end
        end
    end

    // Presents AW/W/AR starting at the given cycle offsets; returns once all requested are accepted.
    task automatic axi_issue(input bit do_w, input logic [31:0] wa, input logic [31:0] wd,
                             input logic [3:0] ws, input bit do_r, input logic [31:0] ra,
                             input int aw_at, input int w_at, input int ar_at);
        bit aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs;
        int cyc;
        aw_done = !do_w; w_done = !do_w; ar_done = !do_r; cyc = 0;
        while (!(aw_done && w_done && ar_done) && cyc < 300) begin
            if (!aw_done && cyc == aw_at) begin awvalid = 1'b1; awaddr = wa; awprot = 3'($urandom); end
            if (!w_done && cyc == w_at) begin wvalid = 1'b1; wdata = wd; wstrb = ws; end
            if (!ar_done && cyc == ar_at) begin arvalid = 1'b1; araddr = ra; arprot = 3'($urandom); end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            ar_hs = arvalid && arready;
            @(negedge aclk);
            cyc++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; awaddr = $urandom; end
            if (w_hs) begin wvalid = 1'b0; w_done = 1; wdata = $urandom; end
            if (ar_hs) begin arvalid = 1'b0; ar_done = 1; araddr = $urandom; end
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("axi_issue_accepted", {aw_done, w_done, ar_done}, 3'b111);
    endtask

    task automatic collect_b(input int hold, input logic [1:0] exp_resp);
        int n;
        n = 0;
        while (!bvalid && n < 3000) begin @(negedge aclk); n++; end
        check("b_valid_seen", bvalid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            check("b_hold", {bvalid, bresp}, {1'b1, exp_resp});
            @(negedge aclk);
        end
        check("bresp", bresp, exp_resp);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("b_done", bvalid, 1'b0);
    endtask

    task automatic collect_r(input int hold, input logic [31:0] exp_d, input logic [1:0] exp_resp);
        int n;
        n = 0;
        while (!rvalid && n < 3000) begin @(negedge aclk); n++; end
        check("r_valid_seen", rvalid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            check("r_hold", {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_d});
            @(negedge aclk);
        end
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_resp);
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        check("r_done", rvalid, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_readies"}, {awready, wready, arready}, 3'b111);
        check({tag, "_valids"}, {bvalid, rvalid}, 2'b00);
        check({tag, "_resps"}, {bresp, rresp}, 4'b0000);
        check({tag, "_rdata"}, rdata, 32'h0);
        check({tag, "_avmm_cmd"}, {avmm_read_o, avmm_write_o}, 2'b00);
        check({tag, "_avmm_bus"}, {avmm_address_o, avmm_writedata_o, avmm_byteenable_o}, 68'h0);
    endtask

    initial begin : main
        logic [31:0] a, d, exp_d;
        logic [3:0]  s;
        int          sk, n;
        aresetn = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
        #1 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        // W three cycles ahead of AW, unaligned address, zero-wait slave, minimum latency.
        slave_wait = 0; slave_lat = 0;
        expect_write(32'h1006, 32'hA5A5_1234, 4'hC);
        axi_issue(1, 32'h1006, 32'hA5A5_1234, 4'hC, 0, 0, 3, 0, 0);
        check("wr_min_lat_n", avmm_write_o, 1'b0);
        @(negedge aclk);
        check("wr_min_lat_n1", avmm_write_o, 1'b1);
        @(negedge aclk);
        check("wr_min_lat_n2", {avmm_write_o, bvalid}, 2'b01);
        collect_b(0, 2'b00);
        check("wr_pulse_cycles", last_cmd_cycles, 1);

        // Read with waitrequest 4 cycles, readdatavalid 2 cycles later, rready held off 5 cycles.
        expect_write(32'h20, 32'hCAFE_F00D, 4'hF);
        axi_issue(1, 32'h20, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0);
        collect_b(1, 2'b00);
        slave_wait = 4; slave_lat = 2;
        exp_d = expect_read(32'h20);
        axi_issue(0, 0, 0, 0, 1, 32'h20, 0, 0, 0);
        collect_r(5, exp_d, 2'b00);
        check("rd_cmd_held_cycles", last_cmd_cycles, 5);
        check("rd_data_value", exp_d, 32'hCAFE_F00D);

        // AW+W and AR together, twice: write, read, write, read.
        slave_wait = 1; slave_lat = 1;
        for (int k = 0; k < 2; k++) begin
            a = 32'h200 + 32'(k * 8); d = $urandom;
            expect_write(a, d, 4'hF);
            exp_d = expect_read(32'h204 + 32'(k * 8));
            axi_issue(1, a, d, 4'hF, 1, 32'h204 + 32'(k * 8), 0, 0, 0);
            collect_b(1, 2'b00);
            collect_r(1, exp_d, 2'b00);
        end

        // Spurious readdatavalid while idle.
        spur_req = 1;
        repeat (3) begin
            @(negedge aclk);
            check("spurious_no_rvalid", rvalid, 1'b0);
        end
        slave_wait = 0; slave_lat = 0;
        exp_d = expect_read(32'h1004);
        axi_issue(0, 0, 0, 0, 1, 32'h1004, 0, 0, 0);
        collect_r(0, exp_d, 2'b00);

        // Asynchronous reset while waiting for read data.
        slave_lat = 10;
        exp_d = expect_read(32'h20);
        axi_issue(0, 0, 0, 0, 1, 32'h20, 0, 0, 0);
        repeat (3) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("midrd_reset");
        @(negedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        slave_lat = 1;
        exp_d = expect_read(32'h20);
        axi_issue(0, 0, 0, 0, 1, 32'h20, 0, 0, 0);
        collect_r(1, exp_d, 2'b00);

`ifdef AXILITE2AVMM_TIMEOUT_EN
        // No readdatavalid: SLVERR after 16 cycles in RD_WAIT; stuck waitrequest on a write.
        slave_no_rdv = 1; slave_wait = 0;
        exp_d = expect_read(32'h40);
        axi_issue(0, 0, 0, 0, 1, 32'h40, 0, 0, 0);
        n = 0;
        while (!rvalid && n < 200) begin @(negedge aclk); n++; end
        check("rd_timeout_latency", int'(($time - acc_time) / 10), 17);
        collect_r(1, 32'hDEAD_BEEF, 2'b10);
        slave_no_rdv = 0; slave_wait = 100000;
        axi_issue(1, 32'h44, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0);
        collect_b(1, 2'b10);
        slave_wait = 0;
        exp_d = expect_read(32'h44);
        axi_issue(0, 0, 0, 0, 1, 32'h44, 0, 0, 0);
        collect_r(0, exp_d, 2'b00);
`endif

        // Randomized single transactions against the reference memory.
        for (int t = 0; t < 40; t++) begin
            a = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            slave_wait = $urandom_range(0, 3);
            slave_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                sk = int'($urandom_range(0, 6)) - 3;
                expect_write(a, d, s);
                axi_issue(1, a, d, s, 0, 0, (sk > 0) ? sk : 0, (sk < 0) ? -sk : 0, 0);
                collect_b($urandom_range(0, 3), 2'b00);
            end else begin
                exp_d = expect_read(a);
                axi_issue(0, 0, 0, 0, 1, a, 0, 0, $urandom_range(0, 2));
                collect_r($urandom_range(0, 3), exp_d, 2'b00);
            end
        end

        repeat (3) @(negedge aclk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axilite2avmm_bridge.md
Name: axilite2avmm_bridge

Overview:
- AXI4-Lite slave to Avalon-MM master bridge; the counterpart of the existing AVMM-to-AXI-Lite bridge in the CVL BFM.
- Lets an AXI-Lite initiator (BFM/testbench driver) access AVMM-register-based CSR blocks.
- Buffers AW, W and AR independently, arbitrates read vs write, and runs one AVMM transaction at a time.
- Holds B/R responses until accepted.

Parameters:
- ADDR_WIDTH, 32, AXI and AVMM address width (byte address).
- DATA_WIDTH, 32, data width; only 32 is supported.
- TIMEOUT_CYCLES, 256, AVMM response timeout in cycles; used only with AXILITE2AVMM_TIMEOUT_EN.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- axi_lite_awvalid_i / axi_lite_awready_o  in/out  1  write address handshake
- axi_lite_awaddr_i  in  ADDR_WIDTH  write address
- axi_lite_awprot_i  in  3  ignored
- axi_lite_wvalid_i / axi_lite_wready_o  in/out  1  write data handshake
- axi_lite_wdata_i  in  DATA_WIDTH  write data
- axi_lite_wstrb_i  in  DATA_WIDTH/8  byte strobes
- axi_lite_bvalid_o / axi_lite_bready_i  out/in  1  write response handshake
- axi_lite_bresp_o  out  2  write response
- axi_lite_arvalid_i / axi_lite_arready_o  in/out  1  read address handshake
- axi_lite_araddr_i  in  ADDR_WIDTH  read address
- axi_lite_arprot_i  in  3  ignored
- axi_lite_rvalid_o / axi_lite_rready_i  out/in  1  read data handshake
- axi_lite_rdata_o  out  DATA_WIDTH  read data
- axi_lite_rresp_o  out  2  read response
- avmm_address_o  out  ADDR_WIDTH  word-aligned byte address
- avmm_writedata_o  out  DATA_WIDTH  write data
- avmm_byteenable_o  out  DATA_WIDTH/8  byte enables
- avmm_write_o / avmm_read_o  out  1  AVMM commands
- avmm_waitrequest_i  in  1  AVMM stall
- avmm_readdata_i  in  DATA_WIDTH  read data
- avmm_readdatavalid_i  in  1  read data valid

Behaviour:
- Reset (async, aresetn low), all outputs and state cleared:
  - awready/wready/arready = 1 (buffers empty), bvalid/rvalid = 0, bresp/rresp = 2'b00, rdata = 0.
  - avmm_read/write = 0, address/writedata/byteenable = 0.
  - FSM = IDLE, round-robin flag = write-first.
- Capture buffers (one entry each: AW, W, AR):
  - Each *ready_o = !buffer_full.
  - A buffer loads on valid&ready and clears when its AVMM command is accepted.
  - AW and W may arrive in either order or in the same cycle.
- Address: avmm_address_o = {addr[ADDR_WIDTH-1:2],2'b00}; byteenable = wstrb; writedata = wdata unshifted.
- FSM:
  - IDLE:
    - write_pending = AW & W full; read_pending = AR full.
    - Both pending: serve the side opposite to the last served (flag toggles per grant).
    - Otherwise serve whichever is pending; stay in IDLE if neither.
  - WR_CMD: avmm_write_o = 1 with stable addr/data/be. When avmm_waitrequest_i = 0: clear AW/W buffers, go to WR_RESP.
  - WR_RESP: bvalid_o = 1, bresp = OKAY. On bready, go to IDLE.
  - RD_CMD: avmm_read_o = 1. When waitrequest = 0: clear AR buffer, go to RD_WAIT.
  - RD_WAIT: on avmm_readdatavalid_i, register readdata into rdata_o and go to RD_RESP.
  - RD_RESP: rvalid_o = 1, rresp = OKAY. On rready, go to IDLE.
- Timing:
  - The AVMM command asserts the cycle after the FSM leaves IDLE.
  - Minimum write: AW&W accepted at edge N, avmm_write_o high after N+1, bvalid high after N+2 (zero wait).
  - Minimum read: arready edge N, avmm_read_o after N+1, rvalid the cycle after readdatavalid.
- Only one AVMM transaction is outstanding.
- New AW/W/AR may be buffered while another transaction is in progress.
- avmm_readdatavalid_i outside RD_WAIT is ignored.
- bvalid/rvalid and response data stay stable until ready is asserted; back-pressure of any length is supported.
- avmm_read_o and avmm_write_o are never high together.
- Reset mid-transaction aborts immediately, with all outputs at reset values.

Optional Feature:
- Macro: AXILITE2AVMM_TIMEOUT_EN.
- When defined:
  - A counter runs in WR_CMD, RD_CMD and RD_WAIT and resets on every state entry.
  - On reaching TIMEOUT_CYCLES, the AVMM command is dropped and the buffer cleared.
  - Write timeout: go to WR_RESP with bresp = SLVERR (2'b10).
  - Read timeout: go to RD_RESP with rresp = SLVERR and rdata = 32'hDEADBEEF.
  - A late readdatavalid after timeout is ignored.
- When undefined: no counter; the bridge waits indefinitely and responses are always OKAY.

Test Plan:
- Write, W before AW by 3 cycles, awaddr = 0x1006, wdata = 0xA5A5_1234, wstrb = 0xC, zero wait -> one avmm_write pulse with address 0x1004, be = 0xC, data 0xA5A5_1234; bvalid once with bresp = 00.
- Read 0x20, waitrequest high 4 cycles, readdatavalid 2 cycles later with 0xCAFE_F00D, rready low 5 cycles -> single avmm_read held 5 cycles; rvalid held with rdata = 0xCAFE_F00D until rready.
- AW+W and AR presented in the same cycle, twice in a row -> AVMM order is write, read, write, read (round-robin); read and write never overlap.
- Spurious readdatavalid in IDLE with data 0x1111_1111 -> no rvalid; a following read returns the correct data.
- aresetn asserted while in RD_WAIT -> all outputs at reset values in the same cycle; a following read completes normally.
- With AXILITE2AVMM_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no readdatavalid -> after 16 cycles in RD_WAIT, rvalid with rresp = 10 and rdata = 0xDEADBEEF; a stuck waitrequest on a write -> bresp = 10.
